load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: max cycles to wait for cache completion.
REQ-002 Parameter DRAIN_CYCLES, default 16: post-reset holdoff before first request is accepted.
REQ-003 Ports: one clock; reset is synchronous and active-high:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- boot_done  in  1  memory boot complete; no cache traffic before it.
- req_valid  in  1  CPU load/store request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_BITS  byte address.
- req_wdata  in  WORD_BITS  store data.
- req_ready  out  1  unit idle and able to accept.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  WORD_BITS  load data, valid with rsp_valid.
- rsp_err  out  1  error flag, valid with rsp_valid.
- stall  out  1  CPU must hold its pipeline.
- wr_en, wr_addr, wr_data  out  1/ADDR_BITS/WORD_BITS  to data cache write port.
- wr_done  in  1  cache write-complete level.
- rd_en, rd_addr  out  1/ADDR_BITS  to data cache read port.
- rd_data  in  WORD_BITS; rd_done  in  1  cache read result and completion level.

Function
REQ-004 States: DRAIN, IDLE, ISSUE, WAIT; encoded in 2 bits.
REQ-005 DRAIN: count DRAIN_CYCLES cycles, then IDLE only if boot_done=1; otherwise remain in DRAIN with count saturated.
REQ-006 req_ready = 1 only in IDLE; stall = req_valid & ~req_ready, or any state other than IDLE.
REQ-007 Acceptance: req_valid & req_ready at posedge; addr, we, wdata captured into registers.
REQ-008 Misaligned request (req_addr[0]=1): no cache access; rsp_valid=1, rsp_err=1, rsp_rdata=0 the cycle after acceptance; stay IDLE.
REQ-009 Aligned request: go to ISSUE; in ISSUE, assert exactly one of wr_en (store) or rd_en (load) for exactly one cycle with registered address/data.
REQ-010 wr_addr/rd_addr/wr_data are held stable from ISSUE until the response pulse.
REQ-011 ISSUE -> WAIT unconditionally; the selected done line is not sampled in ISSUE, since the cache deasserts it the following cycle.
REQ-012 WAIT: on the selected done (wr_done for store, rd_done for load) = 1, pulse rsp_valid next cycle, rsp_err=0, rsp_rdata = rd_data for loads or 0 for stores; return to IDLE.
REQ-013 WAIT: a 10-bit timeout counter cleared on ISSUE, incremented per WAIT cycle; at TIMEOUT_CYCLES without done, pulse rsp_valid with rsp_err=1, rsp_rdata=0, return to IDLE.
REQ-014 The done line of the non-selected port is ignored.
REQ-015 req_valid arriving in WAIT or ISSUE is not accepted; the CPU holds it; no request queueing (depth 1).
REQ-016 Back-to-back: earliest next acceptance is the cycle rsp_valid is high; minimum aligned transaction is 4 cycles accept-to-response.
REQ-017 wr_en and rd_en are never high simultaneously and never high outside ISSUE.
REQ-018 boot_done falling after DRAIN is ignored.

Reset
REQ-019 rst=1 at posedge: state=DRAIN, drain and timeout counters=0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, wr_en=0, rd_en=0, address/data registers=0.
REQ-020 Reset mid-transaction abandons it with no response; DRAIN gives the non-reset cache time to finish and return to its idle state.
REQ-021 All outputs are registered; none changes before the first posedge with rst=0.

Verification
REQ-022 Reset then boot_done=1 at cycle 3 -> req_ready=1 exactly DRAIN_CYCLES+1 cycles after rst falls; wr_en=rd_en=0 throughout.
REQ-023 Store addr 0x0010 data 0xBEEF, cache model raises wr_done 2 cycles after wr_en -> single wr_en pulse with wr_addr=0x0010 and wr_data=0xBEEF; rsp_valid=1, rsp_err=0 one cycle after wr_done.
REQ-024 Load addr 0x0020, cache returns rd_data=0x1234 with rd_done after 5 cycles -> rsp_rdata=0x1234, rsp_err=0, stall high from acceptance to response.
REQ-025 Load addr 0x0021 -> no rd_en; rsp_valid with rsp_err=1 next cycle.
REQ-026 Store with wr_done held 0 -> rsp_err=1 after TIMEOUT_CYCLES in WAIT; next request accepted normally.
REQ-027 rst asserted in WAIT, then late rd_done arrives during DRAIN -> no rsp_valid; normal operation after DRAIN.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Single-outstanding load/store sequencer between a CPU request port and a
//   data cache with separate write and read ports. After reset it holds off
//   for a drain period so that a cache which was not reset can finish any
//   abandoned access. It then waits for memory boot before it serves
//   requests. Misaligned (odd) addresses are rejected without any cache
//   traffic. Every cache access is bounded by a timeout.
//
//   State table
//   state | meaning
//   DRAIN | post-reset holdoff; counts DRAIN_CYCLES, then waits for boot_done
//   IDLE  | req_ready high; accepts one request
//   ISSUE | one-cycle wr_en or rd_en strobe; done lines not sampled
//   WAIT  | waits for the selected done line or for the timeout
//
//   Ports
//   clk, rst              clock; synchronous active-high reset
//   boot_done             memory boot complete (only looked at in DRAIN)
//   req_*                 CPU request: valid, we (1=store), byte addr, store data
//   req_ready, stall      handshake / pipeline hold to the CPU
//   rsp_valid/rdata/err   one-cycle completion pulse with load data and error flag
//   wr_en/addr/data/done  cache write port
//   rd_en/addr/data/done  cache read port
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 1023,
    parameter int DRAIN_CYCLES   = 16,
    parameter int ADDR_BITS      = 16,
    parameter int WORD_BITS      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 boot_done,
    input  logic                 req_valid,
    input  logic                 req_we,
    input  logic [ADDR_BITS-1:0] req_addr,
    input  logic [WORD_BITS-1:0] req_wdata,
    output logic                 req_ready,
    output logic                 rsp_valid,
    output logic [WORD_BITS-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 stall,
    output logic                 wr_en,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [WORD_BITS-1:0] wr_data,
    input  logic                 wr_done,
    output logic                 rd_en,
    output logic [ADDR_BITS-1:0] rd_addr,
    input  logic [WORD_BITS-1:0] rd_data,
    input  logic                 rd_done
);

    localparam logic [1:0] ST_DRAIN = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_ISSUE = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    localparam int DRAIN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES);
    // tmo_cnt holds the number of WAIT cycles already spent, so the last
    // permitted WAIT cycle is the one where it reads TIMEOUT_CYCLES-1.
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYCLES - 1);

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [9:0]           tmo_cnt;
    logic                 we_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [WORD_BITS-1:0] wdata_q;

    logic accept;
    logic misaligned;
    logic sel_done;
    logic wait_done;
    logic wait_tmo;

    assign accept     = req_valid & req_ready;
    assign misaligned = req_addr[0];
    // Only the port that was actually strobed is listened to.
    assign sel_done   = we_q ? wr_done : rd_done;
    assign wait_done  = (state == ST_WAIT) & sel_done;
    // A done on the final WAIT cycle takes priority over the timeout.
    assign wait_tmo   = (state == ST_WAIT) & ~sel_done & (tmo_cnt == TMO_LAST);

    assign wr_addr = addr_q;
    assign rd_addr = addr_q;
    assign wr_data = wdata_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_DRAIN: if ((drain_cnt == DRAIN_LAST) && boot_done) state_nxt = ST_IDLE;
            ST_IDLE:  if (accept && !misaligned) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (wait_done || wait_tmo) state_nxt = ST_IDLE;
            default:  state_nxt = ST_DRAIN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
            tmo_cnt   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            req_ready <= 1'b0;
            stall     <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
        end else begin
            state     <= state_nxt;
            // req_ready/stall are registered copies of the next-state decode
            // so that they line up exactly with the state register.
            req_ready <= (state_nxt == ST_IDLE);
            stall     <= (state_nxt != ST_IDLE);

            if ((state == ST_DRAIN) && (drain_cnt != DRAIN_LAST))
                drain_cnt <= drain_cnt + DRAIN_W'(1);

            if (state == ST_ISSUE)
                tmo_cnt <= '0;
            else if (state == ST_WAIT)
                tmo_cnt <= tmo_cnt + 10'd1;

            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end

            wr_en <= accept & ~misaligned & req_we;
            rd_en <= accept & ~misaligned & ~req_we;

            rsp_valid <= 1'b0;
            if (accept && misaligned) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end else if (wait_done) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_rdata <= we_q ? '0 : rd_data;
            end else if (wait_tmo) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed and randomized transactions against load_store_unit. A small
//   behavioural cache answers each strobe after a chosen latency. The
//   expected response cycle, error flag and data come from transaction-level
//   arithmetic: a misaligned request answers 1 cycle after acceptance.
//   Otherwise the answer comes min(latency, TIMEOUT) + 2 cycles after
//   acceptance, and it is an error when latency > TIMEOUT.
module tb_load_store_unit;

    localparam int T = 1023;
    localparam int D = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        boot_done;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_done;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_done;

    int          total = 0;
    int          bad = 0;
    int          both_hi = 0;
    int          cache_lat = 1;
    logic [15:0] cache_rdata = 16'h0;
    logic        cache_noise = 1'b0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;

    always #5 clk = ~clk;

    load_store_unit #(
        .TIMEOUT_CYCLES(T),
        .DRAIN_CYCLES  (D),
        .ADDR_BITS     (16),
        .WORD_BITS     (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .boot_done(boot_done),
        .req_valid(req_valid),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .stall    (stall),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_done  (wr_done),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_done  (rd_done)
    );

    // Behavioural cache: a strobe drops that port's done level. After
    // cache_lat cycles it raises done again (and presents data for reads).
    // With cache_noise set, the other port's done is also driven high.
    initial begin
        wr_done = 1'b0;
        rd_done = 1'b0;
        rd_data = 16'h0;
        forever begin
            @(negedge clk);
            if (wr_en === 1'b1 && rd_en === 1'b1) both_hi++;
            if (wr_en === 1'b1) begin
                wr_done = 1'b0;
                wr_cnt  = cache_lat;
                if (cache_noise) rd_done = 1'b1;
            end else if (wr_cnt > 0) begin
                wr_cnt--;
                if (wr_cnt == 0) wr_done = 1'b1;
            end
            if (rd_en === 1'b1) begin
                rd_done = 1'b0;
                rd_cnt  = cache_lat;
                rd_data = 16'($urandom);
                if (cache_noise) wr_done = 1'b1;
            end else if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    rd_done = 1'b1;
                    rd_data = cache_rdata;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Called and returns at a negedge.
    task automatic do_req(input string tag, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input int lat, input logic [15:0] rdata,
                          input logic noise, input logic keep);
        int          guard;
        int          n;
        int          expn;
        int          rsp_n;
        int          en_n;
        int          en_cnt;
        int          wrong_cnt;
        int          addr_bad;
        int          stall_bad;
        logic        mis;
        logic        exp_err;
        logic [15:0] exp_data;
        logic        got_err;
        logic [15:0] got_data;
        logic        ready_at_rsp;
        logic        stall_at_rsp;

        mis      = addr[0];
        exp_err  = mis || (lat > T);
        expn     = mis ? 1 : (((lat <= T) ? lat : T) + 2);
        exp_data = (!exp_err && !we) ? rdata : 16'h0;

        cache_lat   = lat;
        cache_rdata = rdata;
        cache_noise = noise;
        req_valid   = 1'b1;
        req_we      = we;
        req_addr    = addr;
        req_wdata   = wdata;

        guard = 0;
        while (req_ready !== 1'b1 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_accepted"}, 32'(req_ready), 32'd1);
        check({tag, "_stall_at_accept"}, 32'(stall), 32'd0);

        @(negedge clk);
        if (!(keep && !mis)) req_valid = 1'b0;
        n = 1; rsp_n = 0; en_n = 0; en_cnt = 0; wrong_cnt = 0;
        addr_bad = 0; stall_bad = 0; got_err = 1'b0; got_data = 16'h0;
        ready_at_rsp = 1'b0; stall_at_rsp = 1'b1;
        while (rsp_n == 0 && n <= expn + 3) begin
            if ((we ? wr_en : rd_en) === 1'b1) begin
                en_cnt++;
                en_n = n;
            end
            if ((we ? rd_en : wr_en) !== 1'b0) wrong_cnt++;
            if (rsp_valid === 1'b1) begin
                rsp_n        = n;
                got_err      = rsp_err;
                got_data     = rsp_rdata;
                ready_at_rsp = req_ready;
                stall_at_rsp = stall;
            end else begin
                if (stall !== 1'b1) stall_bad++;
                if (!mis && (we ? (wr_addr !== addr || wr_data !== wdata) : (rd_addr !== addr)))
                    addr_bad++;
            end
            if (rsp_n == 0) begin
                @(negedge clk);
                n++;
            end
        end
        req_valid = 1'b0;

        check({tag, "_rsp_cycle"}, 32'(rsp_n), 32'(expn));
        check({tag, "_rsp_err"}, 32'(got_err), 32'(exp_err));
        check({tag, "_rsp_rdata"}, 32'(got_data), 32'(exp_data));
        check({tag, "_strobes"}, 32'(en_cnt), mis ? 32'd0 : 32'd1);
        check({tag, "_other_port"}, 32'(wrong_cnt), 32'd0);
        check({tag, "_ready_at_rsp"}, 32'(ready_at_rsp), 32'd1);
        check({tag, "_stall_at_rsp"}, 32'(stall_at_rsp), 32'd0);
        if (!mis) begin
            check({tag, "_strobe_cycle"}, 32'(en_n), 32'd1);
            check({tag, "_addr_data_hold"}, 32'(addr_bad), 32'd0);
            check({tag, "_stall_busy"}, 32'(stall_bad), 32'd0);
        end
    endtask

    initial begin
        int          n;
        int          en_seen;
        int          rsp_seen;
        logic        r_we;
        logic [15:0] r_addr;
        logic [15:0] r_wd;
        logic [15:0] r_rd;
        int          r_lat;
        logic        r_noise;
        logic        r_keep;

        rst = 1'b1; boot_done = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = 16'h0; req_wdata = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_stall", 32'(stall), 32'd1);

        // Drain with boot_done arriving at cycle 3.
        rst = 1'b0; n = 0; en_seen = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (wr_en !== 1'b0 || rd_en !== 1'b0) en_seen++;
            if (n == 3) boot_done = 1'b1;
        end
        check("drain_ready_cycle", 32'(n), 32'(D + 1));
        check("drain_no_cache", 32'(en_seen), 32'd0);

        do_req("st_beef",      1'b1, 16'h0010, 16'hBEEF, 2, 16'h0000, 1'b0, 1'b0);
        do_req("ld_1234",      1'b0, 16'h0020, 16'h0000, 5, 16'h1234, 1'b0, 1'b0);
        do_req("ld_misal",     1'b0, 16'h0021, 16'h0000, 3, 16'h5555, 1'b0, 1'b0);
        do_req("st_misal",     1'b1, 16'h0033, 16'hAAAA, 3, 16'h0000, 1'b0, 1'b0);
        do_req("ld_min_lat",   1'b0, 16'h0102, 16'h0000, 1, 16'h0F0F, 1'b1, 1'b1);
        do_req("st_min_lat",   1'b1, 16'h0104, 16'h9876, 1, 16'h0000, 1'b1, 1'b0);
        do_req("st_timeout",   1'b1, 16'h0200, 16'h1111, 5000, 16'h0000, 1'b0, 1'b0);
        do_req("ld_after_tmo", 1'b0, 16'h0204, 16'h0000, 2, 16'h2222, 1'b0, 1'b0);
        do_req("ld_lat_eq_tmo",   1'b0, 16'h0206, 16'h0000, T, 16'h3333, 1'b0, 1'b0);
        do_req("st_lat_over_tmo", 1'b1, 16'h0208, 16'h4444, T + 1, 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r_we    = 1'($urandom_range(0, 1));
            r_addr  = 16'($urandom);
            r_wd    = 16'($urandom);
            r_rd    = 16'($urandom);
            r_lat   = int'($urandom_range(1, 8));
            r_noise = 1'($urandom_range(0, 1));
            r_keep  = 1'($urandom_range(0, 1));
            do_req("rand", r_we, r_addr, r_wd, r_lat, r_rd, r_noise, r_keep);
        end

        // Drain counter saturates while boot_done is low.
        rst = 1'b1; boot_done = 1'b0;
        @(negedge clk);
        rst = 1'b0; n = 0; en_seen = 0;
        while (n < D + 12) begin
            @(negedge clk);
            n++;
            if (req_ready !== 1'b0) en_seen++;
        end
        check("sat_not_ready", 32'(en_seen), 32'd0);
        boot_done = 1'b1;
        @(negedge clk);
        check("sat_release", 32'(req_ready), 32'd1);
        boot_done = 1'b0;
        do_req("ld_boot_dropped", 1'b0, 16'h0300, 16'h0000, 4, 16'hABCD, 1'b0, 1'b0);
        do_req("st_boot_dropped", 1'b1, 16'h0302, 16'h5A5A, 3, 16'h0000, 1'b0, 1'b0);
        boot_done = 1'b1;

        // Reset while waiting on a slow load; its late rd_done lands in DRAIN.
        cache_lat = 20; cache_rdata = 16'hCAFE; cache_noise = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0040; req_wdata = 16'h0;
        n = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_busy", 32'(stall), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_rd_addr", 32'(rd_addr), 32'd0);
        rst = 1'b0; n = 0; rsp_seen = 0;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
            if (rsp_valid !== 1'b0) rsp_seen++;
        end
        check("mid_rst_drain_cycle", 32'(n), 32'(D + 1));
        check("mid_rst_no_rsp", 32'(rsp_seen), 32'd0);
        check("mid_rst_late_done", 32'(rd_done), 32'd1);
        do_req("ld_post_rst", 1'b0, 16'h0044, 16'h0000, 3, 16'h7777, 1'b0, 1'b0);
        do_req("st_post_rst", 1'b1, 16'h0046, 16'h8888, 2, 16'h0000, 1'b0, 1'b0);

        check("no_dual_strobe", 32'(both_hi), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
